imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 40 ++++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_byte_packer.sv | 72 +++++++
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory:
// memory geometry, loader state encoding and the big-endian byte insert helper.
// Optional checksum feature: IMEM_LOADER_CKSUM_EN adds CHECK and ERR states.
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 512;
  localparam int IMEM_ADDR_W = 9;

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DONE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERR   = 3'd7
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`endif

  // Place byte b into the big-endian slot picked by lane (lane 0 is the MSB).
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the loader.
// master: the byte source / memory side; slave: the loader itself.
import imem_loader_pkg::*;

interface imem_loader_if #(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes into big-endian 32-bit words. A word is emitted (one-cycle
// word_valid pulse) the cycle after its lane-3 byte, or after a byte_last byte in
// any lane, in which case the unfilled low bytes are zero.
import imem_loader_pkg::*;

module imem_byte_packer (
  input  logic        clk,
  input  logic        R,
  input  logic        clear,
  input  logic        xfer,
  input  logic [7:0]  byte_in,
  input  logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        word_last
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;
  logic        word_last_q, word_last_d;
  logic [31:0] merged;

  // Next lane/accumulator state; the accumulator restarts at zero after each word
  // so a short final word is zero-padded for free.
  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    word_last_d  = 1'b0;
    merged       = insert_byte(acc_q, lane_q, byte_in);
    if (clear) begin
      lane_d = 2'd0;
      acc_d  = '0;
    end else if (xfer) begin
      if (lane_q == 2'd3 || byte_last) begin
        word_d       = merged;
        word_valid_d = 1'b1;
        word_last_d  = byte_last;
        lane_d       = 2'd0;
        acc_d        = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // Register packer state; reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (R) begin
      lane_q       <= 2'd0;
      acc_q        <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      word_last_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      word_last_q  <= word_last_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign word_last  = word_last_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives the program image as a byte stream, writes
// packed words to consecutive word addresses from BASE_WORD and holds the CPU
// pipeline in reset (cpu_hold) until the whole image is in memory.
// Optional: define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_WORD = 0
) (
  input  logic            clk,
  input  logic            R,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic [ADDR_W:0] word_count,
  output logic            overflow
`ifdef IMEM_LOADER_CKSUM_EN
  , output logic          cksum_err
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_WORD);

  state_e            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        xsum_q, xsum_d;
  logic              cksum_err_q, cksum_err_d;
`endif

  logic        xfer, load_xfer, full, restart, clear;
  logic        word_valid, word_last;
  logic [31:0] word;

  assign xfer      = bus.byte_valid && byte_ready_q;
  assign load_xfer = xfer && (state_q == ST_LOAD);
  // Memory is full once DEPTH words are in; further commits are dropped.
  assign full      = (count_q >= DEPTH_C);

  imem_byte_packer u_packer (
    .clk        (clk),
    .R          (R),
    .clear      (clear),
    .xfer       (load_xfer),
    .byte_in    (bus.byte_in),
    .byte_last  (bus.byte_last),
    .word_valid (word_valid),
    .word       (word),
    .word_last  (word_last)
  );

  // FSM next state, address/count bookkeeping and registered status outputs.
  always_comb begin
    state_d      = state_q;
    byte_ready_d = byte_ready_q;
    addr_d       = addr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    clear        = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    xsum_d       = xsum_q;
    restart      = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    if (load_xfer) xsum_d = xsum_q ^ bus.byte_in;
`else
    restart      = start && (state_q == ST_IDLE || state_q == ST_DONE);
`endif

    // A committed word advances the address; past the end it only flags overflow.
    if (word_valid) begin
      if (!full) begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      ST_LOAD: begin
        if (load_xfer && bus.byte_last) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = ST_CHECK;
`else
          byte_ready_d = 1'b0;
`endif
        end
`ifndef IMEM_LOADER_CKSUM_EN
        // Release only after the final word has been committed.
        if (word_valid && word_last) state_d = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CKSUM_EN
      // The checksum byte arrives no earlier than the final commit cycle,
      // so DONE is still entered after the last write.
      ST_CHECK: begin
        if (xfer) begin
          byte_ready_d = 1'b0;
          state_d      = (bus.byte_in == xsum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: ;
    endcase

    if (restart) begin
      state_d      = ST_LOAD;
      byte_ready_d = 1'b1;
      addr_d       = BASE_C;
      count_d      = '0;
      overflow_d   = 1'b0;
      clear        = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      xsum_d       = '0;
`endif
    end

    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_err_d = (state_d == ST_ERR);
`endif
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      addr_q       <= BASE_C;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      xsum_q       <= '0;
      cksum_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
`ifdef IMEM_LOADER_CKSUM_EN
      xsum_q       <= xsum_d;
      cksum_err_q  <= cksum_err_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = word_valid && !full;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign word_count     = count_q;
  assign overflow       = overflow_q;
`ifdef IMEM_LOADER_CKSUM_EN
  assign cksum_err      = cksum_err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance plus a DEPTH=2 instance
// for the overflow and restart scenarios.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk = 1'b0;
  logic R, start, start2;
  logic cpu_hold, done, overflow;
  logic cpu_hold2, done2, overflow2;
  logic [9:0] word_count, word_count2;
`ifdef IMEM_LOADER_CKSUM_EN
  logic cksum_err, cksum_err2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  wa[$];
  logic [31:0] wd[$];
  logic [8:0]  wa2[$];
  logic [31:0] wd2[$];

  imem_loader_if #(.ADDR_W(9)) bus ();
  imem_loader_if #(.ADDR_W(9)) bus2 ();

  imem_loader #(.DEPTH(512), .ADDR_W(9), .BASE_WORD(0)) dut (
    .clk(clk), .R(R), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .word_count(word_count), .overflow(overflow)
`ifdef IMEM_LOADER_CKSUM_EN
    , .cksum_err(cksum_err)
`endif
  );

  imem_loader #(.DEPTH(2), .ADDR_W(9), .BASE_WORD(0)) dut2 (
    .clk(clk), .R(R), .start(start2), .bus(bus2),
    .cpu_hold(cpu_hold2), .done(done2), .word_count(word_count2), .overflow(overflow2)
`ifdef IMEM_LOADER_CKSUM_EN
    , .cksum_err(cksum_err2)
`endif
  );

  always #5 clk = ~clk;

  // Write monitors: record every memory write strobe.
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) begin wa.push_back(bus.imem_addr); wd.push_back(bus.imem_wdata); end
    if (bus2.imem_we === 1'b1) begin wa2.push_back(bus2.imem_addr); wd2.push_back(bus2.imem_wdata); end
  end

  // Present one byte at a negedge and return at the negedge after it is taken.
  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    bus.byte_in = b; bus.byte_valid = 1'b1; bus.byte_last = last;
    while (bus.byte_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin n_cmp++; n_bad++; $display("FAIL send_timeout: byte_ready=%b required 1", bus.byte_ready); end
    @(negedge clk);
  endtask

  task automatic send2(input logic [7:0] b, input logic last);
    int n = 0;
    bus2.byte_in = b; bus2.byte_valid = 1'b1; bus2.byte_last = last;
    while (bus2.byte_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin n_cmp++; n_bad++; $display("FAIL send2_timeout: byte_ready=%b required 1", bus2.byte_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset;
    R = 1'b1;
    repeat (2) @(negedge clk);
    R = 1'b0;
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", done); end
    n_cmp++; if (bus.byte_ready !== 1'b0) begin n_bad++; $display("FAIL rst_byte_ready: got %b required 0", bus.byte_ready); end
    n_cmp++; if (bus.imem_addr !== 9'd0) begin n_bad++; $display("FAIL rst_addr: got %0d required 0", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h required 0", bus.imem_wdata); end
    n_cmp++; if (word_count !== 10'd0) begin n_bad++; $display("FAIL rst_word_count: got %0d required 0", word_count); end
    n_cmp++; if (overflow !== 1'b0 || overflow2 !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b/%b required 0/0", overflow, overflow2); end
    repeat (3) @(negedge clk);
    n_cmp++; if (cpu_hold !== 1'b1 || cpu_hold2 !== 1'b1) begin n_bad++; $display("FAIL idle_hold: got %b/%b required 1/1", cpu_hold, cpu_hold2); end
    n_cmp++; if (wd.size() != 0 || wd2.size() != 0) begin n_bad++; $display("FAIL idle_no_write: got %0d/%0d writes required 0", wd.size(), wd2.size()); end
  endtask

  task automatic test_two_words;
    wa.delete(); wd.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    n_cmp++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h05060708) begin n_bad++; $display("FAIL tw_last_commit: we=%b data=%h required 1/05060708", bus.imem_we, bus.imem_wdata); end
    n_cmp++; if (bus.byte_ready !== 1'b0) begin n_bad++; $display("FAIL tw_ready_drop: got %b required 0", bus.byte_ready); end
    n_cmp++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL tw_hold_during_write: hold=%b done=%b required 1/0", cpu_hold, done); end
    bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_bad++; $display("FAIL tw_release: done=%b hold=%b required 1/0", done, cpu_hold); end
    n_cmp++; if (word_count !== 10'd2) begin n_bad++; $display("FAIL tw_word_count: got %0d required 2", word_count); end
    n_cmp++; if (wd.size() != 2) begin n_bad++; $display("FAIL tw_write_count: got %0d required 2", wd.size()); end
    n_cmp++; if (wa[0] !== 9'd0 || wd[0] !== 32'h01020304) begin n_bad++; $display("FAIL tw_word0: addr=%0d data=%h required 0/01020304", wa[0], wd[0]); end
    n_cmp++; if (wa[1] !== 9'd1 || wd[1] !== 32'h05060708) begin n_bad++; $display("FAIL tw_word1: addr=%0d data=%h required 1/05060708", wa[1], wd[1]); end
  endtask

  task automatic test_toggle_valid;
    logic [7:0] img [3];
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    wa.delete(); wd.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_cmp++; if (bus.imem_addr !== 9'd0 || word_count !== 10'd0) begin n_bad++; $display("FAIL tv_restart_addr: addr=%0d count=%0d required 0/0", bus.imem_addr, word_count); end
    for (int i = 0; i < 3; i++) begin
      send(img[i], i == 2);
      bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
      if (i < 2) @(negedge clk);
    end
    n_cmp++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'hAABBCC00) begin n_bad++; $display("FAIL tv_pad_commit: we=%b data=%h required 1/aabbcc00", bus.imem_we, bus.imem_wdata); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || word_count !== 10'd1) begin n_bad++; $display("FAIL tv_done: done=%b count=%0d required 1/1", done, word_count); end
    n_cmp++; if (wd.size() != 1 || wa[0] !== 9'd0 || wd[0] !== 32'hAABBCC00) begin n_bad++; $display("FAIL tv_write: n=%0d addr=%0d data=%h required 1/0/aabbcc00", wd.size(), wa[0], wd[0]); end
  endtask

  task automatic test_overflow;
    wa2.delete(); wd2.delete();
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 12; i++) send2(8'h10 + 8'(i), i == 11);
    n_cmp++; if (bus2.imem_we !== 1'b0) begin n_bad++; $display("FAIL ov_suppress: we=%b required 0", bus2.imem_we); end
    bus2.byte_valid = 1'b0; bus2.byte_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow2 !== 1'b1 || done2 !== 1'b1) begin n_bad++; $display("FAIL ov_flags: overflow=%b done=%b required 1/1", overflow2, done2); end
    n_cmp++; if (word_count2 !== 10'd2) begin n_bad++; $display("FAIL ov_word_count: got %0d required 2", word_count2); end
    n_cmp++; if (wd2.size() != 2) begin n_bad++; $display("FAIL ov_write_count: got %0d required 2", wd2.size()); end
    n_cmp++; if (wd2[0] !== 32'h10111213 || wd2[1] !== 32'h14151617) begin n_bad++; $display("FAIL ov_data: got %h %h required 10111213 14151617", wd2[0], wd2[1]); end
  endtask

  task automatic test_reset_mid_load;
    wa.delete(); wd.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h21 + 8'(i), 1'b0);
    R = 1'b1; bus.byte_valid = 1'b0;
    @(negedge clk);
    R = 1'b0;
    n_cmp++; if (bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL rm_bus: ready=%b we=%b required 0/0", bus.byte_ready, bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 9'd0 || bus.imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rm_addr_data: addr=%0d data=%h required 0/0", bus.imem_addr, bus.imem_wdata); end
    n_cmp++; if (cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 10'd0) begin n_bad++; $display("FAIL rm_status: hold=%b done=%b count=%0d required 1/0/0", cpu_hold, done, word_count); end
    repeat (4) @(negedge clk);
    n_cmp++; if (wd.size() != 1 || wd[0] !== 32'h21222324) begin n_bad++; $display("FAIL rm_writes: n=%0d data=%h required 1/21222324", wd.size(), wd[0]); end
  endtask

  task automatic test_restart;
    logic [7:0] img [4];
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4;
    wa2.delete(); wd2.delete();
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    n_cmp++; if (overflow2 !== 1'b0 || bus2.imem_addr !== 9'd0) begin n_bad++; $display("FAIL rs_clear: overflow=%b addr=%0d required 0/0", overflow2, bus2.imem_addr); end
    n_cmp++; if (done2 !== 1'b0 || cpu_hold2 !== 1'b1) begin n_bad++; $display("FAIL rs_hold: done=%b hold=%b required 0/1", done2, cpu_hold2); end
    for (int i = 0; i < 4; i++) send2(img[i], i == 3);
    bus2.byte_valid = 1'b0; bus2.byte_last = 1'b0;
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b1 || word_count2 !== 10'd1) begin n_bad++; $display("FAIL rs_done: done=%b count=%0d required 1/1", done2, word_count2); end
    n_cmp++; if (wd2.size() != 1 || wa2[0] !== 9'd0 || wd2[0] !== 32'hA1B2C3D4) begin n_bad++; $display("FAIL rs_write: n=%0d addr=%0d data=%h required 1/0/a1b2c3d4", wd2.size(), wa2[0], wd2[0]); end
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  task automatic test_cksum;
    wa.delete(); wd.delete();
    start = 1'b1; @(negedge clk); start = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b1); send(8'h33, 1'b0);
    bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
    n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0 || cksum_err !== 1'b0) begin n_bad++; $display("FAIL ck_match: done=%b hold=%b err=%b required 1/0/0", done, cpu_hold, cksum_err); end
    n_cmp++; if (wd.size() != 1 || wd[0] !== 32'h11220000) begin n_bad++; $display("FAIL ck_write: n=%0d data=%h required 1/11220000", wd.size(), wd[0]); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b1); send(8'h34, 1'b0);
    bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
    n_cmp++; if (cksum_err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ck_mismatch: err=%b hold=%b done=%b required 1/1/0", cksum_err, cpu_hold, done); end
  endtask
`endif

  initial begin
    R = 1'b1; start = 1'b0; start2 = 1'b0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
    bus2.byte_in = '0; bus2.byte_valid = 1'b0; bus2.byte_last = 1'b0;
    test_reset;
`ifdef IMEM_LOADER_CKSUM_EN
    test_cksum;
`else
    test_two_words;
    test_toggle_valid;
    test_overflow;
    test_reset_mid_load;
    test_restart;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
